// File: rtl/pipeline_hazard_ctrl.sv
// Stall/flush controller for the 5-stage pipeline: arbitrates D-miss freeze,
// load-use stalls, ID mispredicts and I-miss waits, and keeps two perf counters.
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             IF_ICacheMiss,
  input  logic             MEM_DCacheMiss,
  input  logic             EX_MemRead,
  input  logic [REG_W-1:0] EX_Rd,
  input  logic [REG_W-1:0] ID_SrcA,
  input  logic             ID_SrcAValid,
  input  logic [REG_W-1:0] ID_SrcB,
  input  logic             ID_SrcBValid,
  input  logic             ID_BranchValid,
  input  logic             ID_BranchTaken,
  input  logic             ID_PredictedTaken,
  input  logic [15:0]      ID_BranchTarget,
  input  logic [15:0]      ID_PCPlus2,
  output logic             PC_wen,
  output logic             PC_redirect,
  output logic [15:0]      PC_redirectTarget,
  output logic             IFID_wen,
  output logic             IFID_flush,
  output logic             IDEX_flush,
  output logic             BACK_wen,
  output logic [CNT_W-1:0] MispredictCount,
  output logic [CNT_W-1:0] StallCount
);

  typedef enum logic [1:0] {
    RUN    = 2'd0,
    IWAIT  = 2'd1,
    IDRAIN = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_next_s;
  logic [15:0]       pend_r;
  logic [CNT_W-1:0]  mis_cnt_r;
  logic [CNT_W-1:0]  stall_cnt_r;
  logic              loaduse_s;
  logic              mispred_s;
  logic [15:0]       target_s;
  logic              latch_s;
  logic              count_mis_s;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) begin
      return v;
    end else begin
      return v + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  endfunction

  assign loaduse_s = EX_MemRead & (EX_Rd != {REG_W{1'b0}}) &
                     ((ID_SrcAValid & (ID_SrcA == EX_Rd)) |
                      (ID_SrcBValid & (ID_SrcB == EX_Rd)));
  assign mispred_s = ID_BranchValid & ~loaduse_s & (ID_BranchTaken != ID_PredictedTaken);
  assign target_s  = ID_BranchTaken ? ID_BranchTarget : ID_PCPlus2;

  assign MispredictCount = mis_cnt_r;
  assign StallCount      = stall_cnt_r;

  // Next-state and control outputs; reset and D-miss freeze override everything.
  always_comb begin
    PC_wen            = 1'b1;
    IFID_wen          = 1'b1;
    BACK_wen          = 1'b1;
    PC_redirect       = 1'b0;
    IFID_flush        = 1'b0;
    IDEX_flush        = 1'b0;
    PC_redirectTarget = (state_r == IDRAIN) ? pend_r : target_s;
    state_next_s      = state_r;
    latch_s           = 1'b0;
    count_mis_s       = 1'b0;
    if (!rst) begin
      PC_wen     = 1'b0;
      IFID_wen   = 1'b0;
      BACK_wen   = 1'b0;
      IFID_flush = 1'b1;
      IDEX_flush = 1'b1;
    end else if (MEM_DCacheMiss) begin
      PC_wen   = 1'b0;
      IFID_wen = 1'b0;
      BACK_wen = 1'b0;
    end else begin
      case (state_r)
        RUN: begin
          if (loaduse_s) begin
            PC_wen     = 1'b0;
            IFID_wen   = 1'b0;
            IDEX_flush = 1'b1;
          end else if (mispred_s) begin
            count_mis_s = 1'b1;
            IFID_flush  = 1'b1;
            if (IF_ICacheMiss) begin
              // Fetch is busy on the wrong path; replay the redirect once it lands.
              PC_wen       = 1'b0;
              latch_s      = 1'b1;
              state_next_s = IDRAIN;
            end else begin
              PC_redirect = 1'b1;
            end
          end else if (IF_ICacheMiss) begin
            PC_wen       = 1'b0;
            IFID_flush   = 1'b1;
            state_next_s = IWAIT;
          end else begin
            state_next_s = RUN;
          end
        end
        IWAIT: begin
          if (loaduse_s) begin
            PC_wen     = 1'b0;
            IFID_wen   = 1'b0;
            IFID_flush = IF_ICacheMiss;
            IDEX_flush = 1'b1;
          end else if (mispred_s) begin
            PC_wen       = 1'b0;
            IFID_flush   = 1'b1;
            latch_s      = 1'b1;
            count_mis_s  = 1'b1;
            state_next_s = IDRAIN;
          end else if (IF_ICacheMiss) begin
            PC_wen     = 1'b0;
            IFID_flush = 1'b1;
          end else begin
            state_next_s = RUN;
          end
        end
        IDRAIN: begin
          IFID_flush = 1'b1;
          if (IF_ICacheMiss) begin
            PC_wen = 1'b0;
          end else begin
            PC_redirect  = 1'b1;
            state_next_s = RUN;
          end
        end
        default: begin
          state_next_s = RUN;
        end
      endcase
    end
  end

  // State, pending redirect target and saturating performance counters.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_r     <= RUN;
      pend_r      <= 16'h0000;
      mis_cnt_r   <= {CNT_W{1'b0}};
      stall_cnt_r <= {CNT_W{1'b0}};
    end else begin
      state_r <= state_next_s;
      if (latch_s) begin
        pend_r <= target_s;
      end
      if (count_mis_s) begin
        mis_cnt_r <= sat_inc(mis_cnt_r);
      end
      if (!PC_wen) begin
        stall_cnt_r <= sat_inc(stall_cnt_r);
      end
    end
  end

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl.
module tb_pipeline_hazard_ctrl;

  logic        clk;
  logic        rst;
  logic        IF_ICacheMiss, MEM_DCacheMiss, EX_MemRead;
  logic [3:0]  EX_Rd, ID_SrcA, ID_SrcB;
  logic        ID_SrcAValid, ID_SrcBValid;
  logic        ID_BranchValid, ID_BranchTaken, ID_PredictedTaken;
  logic [15:0] ID_BranchTarget, ID_PCPlus2;
  logic        PC_wen, PC_redirect, IFID_wen, IFID_flush, IDEX_flush, BACK_wen;
  logic [15:0] PC_redirectTarget, MispredictCount, StallCount;

  int checks = 0;
  int errors = 0;

  pipeline_hazard_ctrl #(.CNT_W(16), .REG_W(4)) dut (
    .clk(clk), .rst(rst),
    .IF_ICacheMiss(IF_ICacheMiss), .MEM_DCacheMiss(MEM_DCacheMiss),
    .EX_MemRead(EX_MemRead), .EX_Rd(EX_Rd),
    .ID_SrcA(ID_SrcA), .ID_SrcAValid(ID_SrcAValid),
    .ID_SrcB(ID_SrcB), .ID_SrcBValid(ID_SrcBValid),
    .ID_BranchValid(ID_BranchValid), .ID_BranchTaken(ID_BranchTaken),
    .ID_PredictedTaken(ID_PredictedTaken),
    .ID_BranchTarget(ID_BranchTarget), .ID_PCPlus2(ID_PCPlus2),
    .PC_wen(PC_wen), .PC_redirect(PC_redirect), .PC_redirectTarget(PC_redirectTarget),
    .IFID_wen(IFID_wen), .IFID_flush(IFID_flush), .IDEX_flush(IDEX_flush),
    .BACK_wen(BACK_wen), .MispredictCount(MispredictCount), .StallCount(StallCount)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic idle_inputs();
    IF_ICacheMiss = 1'b0; MEM_DCacheMiss = 1'b0; EX_MemRead = 1'b0;
    EX_Rd = 4'd0; ID_SrcA = 4'd0; ID_SrcB = 4'd0;
    ID_SrcAValid = 1'b0; ID_SrcBValid = 1'b0;
    ID_BranchValid = 1'b0; ID_BranchTaken = 1'b0; ID_PredictedTaken = 1'b0;
    ID_BranchTarget = 16'h0000; ID_PCPlus2 = 16'h0000;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    @(negedge clk);
    checks++; if (PC_wen !== 1'b0 || IFID_wen !== 1'b0 || BACK_wen !== 1'b0) begin errors++; $display("FAIL reset_wen: got pc=%b ifid=%b back=%b expected 0 0 0", PC_wen, IFID_wen, BACK_wen); end
    checks++; if (IFID_flush !== 1'b1 || IDEX_flush !== 1'b1 || PC_redirect !== 1'b0) begin errors++; $display("FAIL reset_flush: got ifid=%b idex=%b redir=%b expected 1 1 0", IFID_flush, IDEX_flush, PC_redirect); end
    checks++; if (StallCount !== 16'h0000 || MispredictCount !== 16'h0000) begin errors++; $display("FAIL reset_counts: got stall=%h mis=%h expected 0 0", StallCount, MispredictCount); end
    rst = 1'b1;
    tick();
    @(negedge clk);
    checks++; if (PC_wen !== 1'b1 || IFID_wen !== 1'b1 || BACK_wen !== 1'b1 || IFID_flush !== 1'b0 || IDEX_flush !== 1'b0 || PC_redirect !== 1'b0) begin errors++; $display("FAIL idle_defaults: got pc=%b ifid=%b back=%b iff=%b idf=%b redir=%b expected 1 1 1 0 0 0", PC_wen, IFID_wen, BACK_wen, IFID_flush, IDEX_flush, PC_redirect); end
    tick();
  endtask

  task automatic test_load_use();
    EX_MemRead = 1'b1; EX_Rd = 4'd3; ID_SrcA = 4'd3; ID_SrcAValid = 1'b1;
    @(negedge clk);
    checks++; if (PC_wen !== 1'b0 || IFID_wen !== 1'b0 || IDEX_flush !== 1'b1 || BACK_wen !== 1'b1) begin errors++; $display("FAIL loaduse_a: got pc=%b ifid=%b idf=%b back=%b expected 0 0 1 1", PC_wen, IFID_wen, IDEX_flush, BACK_wen); end
    tick(); idle_inputs();
    checks++; if (StallCount !== 16'd1) begin errors++; $display("FAIL loaduse_stallcnt: got %0d expected 1", StallCount); end
    @(negedge clk);
    checks++; if (PC_wen !== 1'b1 || IDEX_flush !== 1'b0) begin errors++; $display("FAIL loaduse_after: got pc=%b idf=%b expected 1 0", PC_wen, IDEX_flush); end
    tick();
    EX_MemRead = 1'b1; EX_Rd = 4'd0; ID_SrcA = 4'd0; ID_SrcAValid = 1'b1;
    @(negedge clk);
    checks++; if (PC_wen !== 1'b1 || IDEX_flush !== 1'b0) begin errors++; $display("FAIL loaduse_r0: got pc=%b idf=%b expected 1 0", PC_wen, IDEX_flush); end
    tick();
    EX_Rd = 4'd5; ID_SrcA = 4'd3; ID_SrcB = 4'd5; ID_SrcBValid = 1'b1;
    @(negedge clk);
    checks++; if (PC_wen !== 1'b0 || IDEX_flush !== 1'b1) begin errors++; $display("FAIL loaduse_b: got pc=%b idf=%b expected 0 1", PC_wen, IDEX_flush); end
    tick();
    ID_SrcBValid = 1'b0;
    @(negedge clk);
    checks++; if (PC_wen !== 1'b1 || IDEX_flush !== 1'b0) begin errors++; $display("FAIL loaduse_b_invalid: got pc=%b idf=%b expected 1 0", PC_wen, IDEX_flush); end
    tick(); idle_inputs();
    checks++; if (StallCount !== 16'd2) begin errors++; $display("FAIL loaduse_stallcnt2: got %0d expected 2", StallCount); end
  endtask

  task automatic test_mispredict();
    ID_BranchValid = 1'b1; ID_BranchTaken = 1'b1; ID_PredictedTaken = 1'b0;
    ID_BranchTarget = 16'h0040; ID_PCPlus2 = 16'h0022;
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b1 || PC_redirectTarget !== 16'h0040 || IFID_flush !== 1'b1 || PC_wen !== 1'b1 || IDEX_flush !== 1'b0) begin errors++; $display("FAIL mispred_taken: got redir=%b tgt=%h iff=%b pc=%b idf=%b expected 1 0040 1 1 0", PC_redirect, PC_redirectTarget, IFID_flush, PC_wen, IDEX_flush); end
    tick();
    checks++; if (MispredictCount !== 16'd1) begin errors++; $display("FAIL mispred_cnt1: got %0d expected 1", MispredictCount); end
    ID_BranchTaken = 1'b0; ID_PredictedTaken = 1'b1; ID_PCPlus2 = 16'h0012;
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b1 || PC_redirectTarget !== 16'h0012) begin errors++; $display("FAIL mispred_nottaken: got redir=%b tgt=%h expected 1 0012", PC_redirect, PC_redirectTarget); end
    tick();
    checks++; if (MispredictCount !== 16'd2) begin errors++; $display("FAIL mispred_cnt2: got %0d expected 2", MispredictCount); end
    ID_BranchTaken = 1'b1; ID_PredictedTaken = 1'b1;
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b0 || IFID_flush !== 1'b0) begin errors++; $display("FAIL correct_pred: got redir=%b iff=%b expected 0 0", PC_redirect, IFID_flush); end
    tick();
    ID_PredictedTaken = 1'b0; EX_MemRead = 1'b1; EX_Rd = 4'd3; ID_SrcA = 4'd3; ID_SrcAValid = 1'b1;
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b0 || IDEX_flush !== 1'b1 || PC_wen !== 1'b0) begin errors++; $display("FAIL loaduse_over_mispred: got redir=%b idf=%b pc=%b expected 0 1 0", PC_redirect, IDEX_flush, PC_wen); end
    tick(); idle_inputs();
    checks++; if (MispredictCount !== 16'd2 || StallCount !== 16'd3) begin errors++; $display("FAIL mispred_counts: got mis=%0d stall=%0d expected 2 3", MispredictCount, StallCount); end
  endtask

  task automatic test_imiss_mispredict();
    ID_BranchValid = 1'b1; ID_BranchTaken = 1'b1; ID_PredictedTaken = 1'b0;
    ID_BranchTarget = 16'h0100; IF_ICacheMiss = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      checks++; if (PC_wen !== 1'b0 || IFID_flush !== 1'b1 || PC_redirect !== 1'b0) begin errors++; $display("FAIL drain_wait%0d: got pc=%b iff=%b redir=%b expected 0 1 0", c, PC_wen, IFID_flush, PC_redirect); end
      tick();
      idle_inputs(); IF_ICacheMiss = (c < 2); ID_BranchTarget = 16'h0BAD;
    end
    checks++; if (MispredictCount !== 16'd3) begin errors++; $display("FAIL drain_mis_cnt: got %0d expected 3", MispredictCount); end
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b1 || PC_redirectTarget !== 16'h0100 || IFID_flush !== 1'b1 || PC_wen !== 1'b1) begin errors++; $display("FAIL drain_redirect: got redir=%b tgt=%h iff=%b pc=%b expected 1 0100 1 1", PC_redirect, PC_redirectTarget, IFID_flush, PC_wen); end
    tick(); idle_inputs();
    checks++; if (StallCount !== 16'd6) begin errors++; $display("FAIL drain_stallcnt: got %0d expected 6", StallCount); end
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b0 || IFID_flush !== 1'b0 || PC_wen !== 1'b1) begin errors++; $display("FAIL drain_back_run: got redir=%b iff=%b pc=%b expected 0 0 1", PC_redirect, IFID_flush, PC_wen); end
    tick();
  endtask

  task automatic test_imiss();
    IF_ICacheMiss = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (PC_wen !== 1'b0 || IFID_flush !== 1'b1) begin errors++; $display("FAIL imiss_wait%0d: got pc=%b iff=%b expected 0 1", c, PC_wen, IFID_flush); end
      tick();
    end
    IF_ICacheMiss = 1'b0;
    @(negedge clk);
    checks++; if (PC_wen !== 1'b1 || IFID_wen !== 1'b1 || IFID_flush !== 1'b0 || PC_redirect !== 1'b0) begin errors++; $display("FAIL imiss_done: got pc=%b ifw=%b iff=%b redir=%b expected 1 1 0 0", PC_wen, IFID_wen, IFID_flush, PC_redirect); end
    tick();
    checks++; if (StallCount !== 16'd8) begin errors++; $display("FAIL imiss_stallcnt: got %0d expected 8", StallCount); end
  endtask

  task automatic test_dmiss_freeze();
    do_reset();
    EX_MemRead = 1'b1; EX_Rd = 4'd7; ID_SrcB = 4'd7; ID_SrcBValid = 1'b1; MEM_DCacheMiss = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checks++; if (PC_wen !== 1'b0 || IFID_wen !== 1'b0 || BACK_wen !== 1'b0 || IFID_flush !== 1'b0 || IDEX_flush !== 1'b0 || PC_redirect !== 1'b0) begin errors++; $display("FAIL dmiss_freeze%0d: got pc=%b ifw=%b back=%b iff=%b idf=%b redir=%b expected 0 0 0 0 0 0", c, PC_wen, IFID_wen, BACK_wen, IFID_flush, IDEX_flush, PC_redirect); end
      tick();
    end
    MEM_DCacheMiss = 1'b0;
    @(negedge clk);
    checks++; if (PC_wen !== 1'b0 || IFID_wen !== 1'b0 || BACK_wen !== 1'b1 || IDEX_flush !== 1'b1) begin errors++; $display("FAIL dmiss_then_loaduse: got pc=%b ifw=%b back=%b idf=%b expected 0 0 1 1", PC_wen, IFID_wen, BACK_wen, IDEX_flush); end
    tick(); idle_inputs();
    checks++; if (StallCount !== 16'd5) begin errors++; $display("FAIL dmiss_stallcnt: got %0d expected 5", StallCount); end
    ID_BranchValid = 1'b1; ID_BranchTaken = 1'b0; ID_PredictedTaken = 1'b1; ID_PCPlus2 = 16'h0200; MEM_DCacheMiss = 1'b1;
    for (int c = 0; c < 2; c++) begin
      @(negedge clk);
      checks++; if (PC_redirect !== 1'b0 || IFID_flush !== 1'b0) begin errors++; $display("FAIL dmiss_mispred_hold%0d: got redir=%b iff=%b expected 0 0", c, PC_redirect, IFID_flush); end
      tick();
    end
    checks++; if (MispredictCount !== 16'd0) begin errors++; $display("FAIL dmiss_mis_held: got %0d expected 0", MispredictCount); end
    MEM_DCacheMiss = 1'b0;
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b1 || PC_redirectTarget !== 16'h0200) begin errors++; $display("FAIL dmiss_mispred_accept: got redir=%b tgt=%h expected 1 0200", PC_redirect, PC_redirectTarget); end
    tick(); idle_inputs();
    checks++; if (MispredictCount !== 16'd1 || StallCount !== 16'd7) begin errors++; $display("FAIL dmiss_counts: got mis=%0d stall=%0d expected 1 7", MispredictCount, StallCount); end
  endtask

  task automatic test_saturation();
    force dut.stall_cnt_r = 16'hFFFE;
    #1;
    release dut.stall_cnt_r;
    EX_MemRead = 1'b1; EX_Rd = 4'd2; ID_SrcA = 4'd2; ID_SrcAValid = 1'b1;
    tick();
    checks++; if (StallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_reach: got %h expected ffff", StallCount); end
    tick(); tick();
    checks++; if (StallCount !== 16'hFFFF) begin errors++; $display("FAIL sat_hold: got %h expected ffff", StallCount); end
    idle_inputs();
  endtask

  task automatic test_reset_in_drain();
    do_reset();
    ID_BranchValid = 1'b1; ID_BranchTaken = 1'b1; ID_PredictedTaken = 1'b0;
    ID_BranchTarget = 16'h0300; IF_ICacheMiss = 1'b1;
    tick();
    idle_inputs(); IF_ICacheMiss = 1'b1;
    @(negedge clk);
    #2 rst = 1'b0;
    #1;
    checks++; if (PC_wen !== 1'b0 || BACK_wen !== 1'b0 || IDEX_flush !== 1'b1 || PC_redirect !== 1'b0) begin errors++; $display("FAIL drain_rst_outs: got pc=%b back=%b idf=%b redir=%b expected 0 0 1 0", PC_wen, BACK_wen, IDEX_flush, PC_redirect); end
    checks++; if (StallCount !== 16'd0 || MispredictCount !== 16'd0) begin errors++; $display("FAIL drain_rst_counts: got stall=%0d mis=%0d expected 0 0", StallCount, MispredictCount); end
    @(negedge clk);
    IF_ICacheMiss = 1'b0; rst = 1'b1;
    #1;
    checks++; if (PC_redirect !== 1'b0 || PC_wen !== 1'b1 || IFID_flush !== 1'b0) begin errors++; $display("FAIL drain_rst_release: got redir=%b pc=%b iff=%b expected 0 1 0", PC_redirect, PC_wen, IFID_flush); end
    tick();
    @(negedge clk);
    checks++; if (PC_redirect !== 1'b0 || PC_wen !== 1'b1 || StallCount !== 16'd0) begin errors++; $display("FAIL drain_rst_after: got redir=%b pc=%b stall=%0d expected 0 1 0", PC_redirect, PC_wen, StallCount); end
  endtask

  initial begin
    rst = 1'b0;
    idle_inputs();
    test_reset();
    test_load_use();
    test_mispredict();
    test_imiss_mispredict();
    test_imiss();
    test_dmiss_freeze();
    test_saturation();
    test_reset_in_drain();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
Name: pipeline_hazard_ctrl

Overview:
Central stall/flush controller for the 5-stage pipeline.
- Drives the write-enable and flush controls of the PC, the IF/ID register (PC, PC+2, instruction, prediction bit), the ID/EX register and the back end.
- Sources: I-cache miss, D-cache miss, load-use hazards and branch mispredictions detected in ID.
- Also holds a pending-redirect register for mispredicts that coincide with an in-flight fetch miss, plus two performance counters.

Parameters:
CNT_W, 16, width of each saturating performance counter
REG_W, 4, register specifier width

Ports:
clk  in  1  clock
rst  in  1  asynchronous, active-low reset
IF_ICacheMiss  in  1  fetch data not valid this cycle
MEM_DCacheMiss  in  1  data access not complete this cycle
EX_MemRead  in  1  instruction in EX is a load
EX_Rd  in  REG_W  load destination register
ID_SrcA  in  REG_W  first source register of instruction in ID
ID_SrcAValid  in  1  ID_SrcA is actually read
ID_SrcB  in  REG_W  second source register of instruction in ID
ID_SrcBValid  in  1  ID_SrcB is actually read
ID_BranchValid  in  1  ID holds a resolved branch
ID_BranchTaken  in  1  actual branch outcome
ID_PredictedTaken  in  1  prediction carried through IF/ID
ID_BranchTarget  in  16  taken target
ID_PCPlus2  in  16  fall-through address
PC_wen  out  1  PC update enable
PC_redirect  out  1  PC loads PC_redirectTarget
PC_redirectTarget  out  16  redirect address
IFID_wen  out  1  IF/ID write enable
IFID_flush  out  1  IF/ID loads NOP, prediction bit 0
IDEX_flush  out  1  ID/EX loads bubble
BACK_wen  out  1  ID/EX, EX/MEM, MEM/WB enable
MispredictCount  out  CNT_W  mispredicts taken
StallCount  out  CNT_W  cycles with PC_wen=0

Behaviour:
- Definitions:
  - loaduse = EX_MemRead & EX_Rd!=0 & ((ID_SrcAValid & ID_SrcA==EX_Rd) | (ID_SrcBValid & ID_SrcB==EX_Rd)).
  - mispred = ID_BranchValid & ~loaduse & (ID_BranchTaken != ID_PredictedTaken).
  - target = ID_BranchTaken ? ID_BranchTarget : ID_PCPlus2.
- Default (no event): PC_wen=1, IFID_wen=1, BACK_wen=1, all flush/redirect outputs 0.
- Priority: D-cache miss > load-use > mispredict > I-cache miss.
- FSM states: RUN, IWAIT, IDRAIN. All outputs are combinational from state and inputs.
- Global freeze, any state: if MEM_DCacheMiss=1:
  - all wen=0, all flush=0, redirect=0.
  - State, target register and MispredictCount hold; StallCount still counts.
- RUN:
  - loaduse: PC_wen=0, IFID_wen=0, IDEX_flush=1; stay RUN.
  - mispred & ~IF_ICacheMiss: PC_redirect=1, PC_redirectTarget=target, IFID_flush=1; count mispredict; stay RUN.
  - mispred & IF_ICacheMiss: PC_wen=0, IFID_flush=1; latch target into the pending register; count mispredict; go to IDRAIN.
  - IF_ICacheMiss only: PC_wen=0, IFID_flush=1; go to IWAIT.
- IWAIT:
  - PC_wen=0 and IFID_flush=1 while IF_ICacheMiss=1.
  - When IF_ICacheMiss=0: default outputs (fetched word enters IF/ID); go to RUN.
  - A mispred in IWAIT (older branch still in ID) latches target and goes to IDRAIN; outputs as in IWAIT.
  - loaduse in IWAIT also asserts IDEX_flush and IFID_wen=0.
- IDRAIN:
  - PC_wen=0 and IFID_flush=1 while IF_ICacheMiss=1.
  - On IF_ICacheMiss=0: discard the fetched word (IFID_flush=1), PC_redirect=1 with PC_redirectTarget = pending register; go to RUN.
  - ID holds only bubbles in IDRAIN; loaduse and mispred cannot occur.
- PC_redirectTarget = pending register in IDRAIN, otherwise target. Don't-care when PC_redirect=0.
- Counters:
  - Saturate at all-ones with no wrap.
  - StallCount increments every cycle PC_wen=0.
  - MispredictCount increments once per accepted mispredict. A mispredict suppressed by a D-cache freeze is counted on the cycle it is accepted.
- Reset:
  - rst=0 asynchronously sets state RUN, pending register 0, counters 0.
  - While rst=0, outputs are forced to PC_wen=0, IFID_wen=0, BACK_wen=0, IFID_flush=1, IDEX_flush=1, PC_redirect=0.
  - Reset asserted mid-IDRAIN drops the pending redirect.

Test Plan:
1. Load-use: EX_MemRead=1, EX_Rd=3, ID_SrcA=3, ID_SrcAValid=1 for 1 cycle -> PC_wen=0, IFID_wen=0, IDEX_flush=1; next cycle defaults; StallCount=1. Repeat with EX_Rd=0 -> no stall.
2. Mispredict: ID_BranchValid=1, Taken=1, Predicted=0, Target=0x0040 -> PC_redirect=1, target 0x0040, IFID_flush=1, MispredictCount=1. Taken=0, Predicted=1, PCPlus2=0x0012 -> target 0x0012.
3. Mispredict coinciding with a 3-cycle I-miss, Target=0x0100 -> state IDRAIN; PC_wen=0 for 3 cycles; miss clears -> PC_redirect=1 with 0x0100 and IFID_flush=1; then RUN.
4. D-miss for 4 cycles during a load-use -> all wen=0 and no flushes for 4 cycles; load-use stall applied on the 5th cycle; StallCount=5.
5. Force StallCount to 0xFFFE, then stall 3 cycles -> counter reads 0xFFFF and holds.
6. Assert rst=0 mid-IDRAIN -> immediate RUN and counters 0; after release, no redirect is issued and default outputs resume.
